tile_frame_responder: RTL and testbench

Pixel-colour responder for the VGA pixel-request interface. The VGA timing side issues a 19-bit pixel ADDRESS, and this block returns the 12-bit COLOUR for that pixel from a 160x120 tile map of 2-bit cell classes mapped through a 4-entry palette. Game logic writes individual tiles through a valid/ready port. A sequential clear engine wipes the whole map on request. The block sits between the game-logic modules and the VGA pixel path.

---
 rtl/tile_pkg.sv | 30 +++
 rtl/tile_ram_dp.sv | 34 +++
 rtl/tile_frame_responder.sv | 156 +++++++++++++++
 tb/tb_tile_frame_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile-map constants, class encodings, FSM state type and index helper
`timescale 1ns/1ps
package tile_pkg;

    localparam int TILES_X    = 160;
    localparam int TILES_Y    = 120;
    localparam int TILE_COUNT = TILES_X * TILES_Y;
    localparam int TILE_SHIFT = 2;
    localparam int IDX_W      = 15;

    typedef enum logic [1:0] {
        CLS_BG     = 2'd0,
        CLS_SNAKE  = 2'd1,
        CLS_TARGET = 2'd2,
        CLS_WALL   = 2'd3
    } cell_class_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_state_e;

    // ty*160 + tx without a multiplier: 160 = 128 + 32.
    function automatic logic [IDX_W-1:0] tile_index(input logic [7:0] tx, input logic [6:0] ty);
        logic [IDX_W-1:0] ty_w;
        ty_w = {8'd0, ty};
        return (ty_w << 7) + (ty_w << 5) + {7'd0, tx};
    endfunction

endpackage

// File: rtl/tile_ram_dp.sv
// rtl/tile_ram_dp.sv - simple dual-port tile RAM, one write port, registered read-first read port
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  registered read data (old contents on a same-address write)
`timescale 1ns/1ps
module tile_ram_dp #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    // Both assignments are non-blocking, so a read of the cell being written
    // returns the value held before this edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/tile_frame_responder.sv
// rtl/tile_frame_responder.sv - VGA pixel-colour responder over a 160x120 tile map with write port and clear engine
// Ports:
//   CLK       system clock
//   RESET     asynchronous active-low reset
//   ADDRESS   pixel request, [18:10]=Y, [9:0]=X
//   COLOUR    palette colour of the requested pixel, two cycles after ADDRESS
//   WR_VALID  tile write request
//   WR_READY  tile write accepted when WR_VALID && WR_READY (IDLE only)
//   WR_ADDR   tile address, [14:7]=tile X, [6:0]=tile Y
//   WR_CLASS  cell class to write
//   CLR_REQ   pulse starting a full-map clear
//   CLR_BUSY  high while the clear engine sweeps the map
`timescale 1ns/1ps
module tile_frame_responder
    import tile_pkg::*;
#(
    parameter logic [11:0] PAL_BG     = 12'h000,
    parameter logic [11:0] PAL_SNAKE  = 12'hFF0,
    parameter logic [11:0] PAL_TARGET = 12'h00F,
    parameter logic [11:0] PAL_WALL   = 12'hF00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [18:0] ADDRESS,
    output logic [11:0] COLOUR,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [14:0] WR_ADDR,
    input  logic [1:0]  WR_CLASS,
    input  logic        CLR_REQ,
    output logic        CLR_BUSY
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_COUNT - 1);

    // ---------------- read path, stage 0 ----------------
    logic [9:0]       px;
    logic [8:0]       py;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    assign px          = ADDRESS[9:0];
    assign py          = ADDRESS[18:10];
    assign rd_in_range = (px < 10'd640) && (py < 9'd480);
    // Blanking addresses would index past the map; park them on cell 0.
    assign rd_idx      = rd_in_range ? tile_index(px[9:TILE_SHIFT], py[8:TILE_SHIFT]) : '0;

    // ---------------- write port decode ----------------
    logic [7:0]       wr_tx;
    logic [6:0]       wr_ty;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;

    assign wr_tx       = WR_ADDR[14:7];
    assign wr_ty       = WR_ADDR[6:0];
    assign wr_in_range = (wr_tx < 8'(TILES_X)) && (wr_ty < 7'(TILES_Y));
    assign wr_idx      = tile_index(wr_tx, wr_ty);

    // ---------------- FSM and write mux ----------------
    fsm_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [1:0]       ram_wdata;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        ram_we    = 1'b0;
        ram_waddr = wr_idx;
        ram_wdata = WR_CLASS;
        case (state_q)
            IDLE: begin
                // Out-of-map writes still complete the handshake but never reach the RAM.
                ram_we = WR_VALID && wr_in_range;
                if (CLR_REQ) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = sweep_q;
                ram_wdata = CLS_BG;
                if (sweep_q == LAST_IDX) begin
                    state_d = IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    assign WR_READY = (state_q == IDLE);
    assign CLR_BUSY = (state_q == CLEAR);

    // ---------------- tile RAM ----------------
    logic [1:0] rd_class;

    tile_ram_dp #(
        .DEPTH (TILE_COUNT),
        .AW    (IDX_W),
        .DW    (2)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_idx),
        .rdata_o (rd_class)
    );

    // ---------------- read path, stage 1 ----------------
    logic        in_range_q;
    logic [11:0] colour_q;
    logic [11:0] pal_colour;

    always_comb begin
        pal_colour = PAL_BG;
        case (rd_class)
            CLS_BG:     pal_colour = PAL_BG;
            CLS_SNAKE:  pal_colour = PAL_SNAKE;
            CLS_TARGET: pal_colour = PAL_TARGET;
            CLS_WALL:   pal_colour = PAL_WALL;
            default:    pal_colour = PAL_BG;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            in_range_q <= 1'b0;
            colour_q   <= 12'h000;
        end else begin
            in_range_q <= rd_in_range;
            colour_q   <= in_range_q ? pal_colour : 12'h000;
        end
    end

    assign COLOUR = colour_q;

endmodule

// File: tb/tb_tile_frame_responder.sv
// tb/tb_tile_frame_responder.sv - self-checking bench for tile_frame_responder
`timescale 1ns/1ps
module tb_tile_frame_responder;

    localparam int TILE_N = 19200;

    logic        CLK      = 1'b0;
    logic        RESET    = 1'b0;
    logic [18:0] ADDRESS  = '0;
    logic [11:0] COLOUR;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [14:0] WR_ADDR  = '0;
    logic [1:0]  WR_CLASS = '0;
    logic        CLR_REQ  = 1'b0;
    logic        CLR_BUSY;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    tile_frame_responder dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDRESS  (ADDRESS),
        .COLOUR   (COLOUR),
        .WR_VALID (WR_VALID),
        .WR_READY (WR_READY),
        .WR_ADDR  (WR_ADDR),
        .WR_CLASS (WR_CLASS),
        .CLR_REQ  (CLR_REQ),
        .CLR_BUSY (CLR_BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pal(input logic [1:0] c);
        case (c)
            2'd0:    return 12'h000;
            2'd1:    return 12'hFF0;
            2'd2:    return 12'h00F;
            default: return 12'hF00;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // Map held as [tile x][tile y]; cells are unknown after reset until cleared.
    logic [1:0]  mmap  [160][120];
    bit          known [160][120];
    logic        m_busy = 1'b1;
    int          m_left = TILE_N;
    logic [11:0] p1 = '0, p2 = '0;
    logic        p1v = 1'b0, p2v = 1'b0;

    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (RESET !== 1'b1) begin
                m_busy = 1'b1;
                m_left = TILE_N;
                p1v    = 1'b0;
                p2v    = 1'b0;
                foreach (known[i, j]) known[i][j] = 1'b0;
            end else begin
                int x, y, n, tx, ty;
                p2  = p1;
                p2v = p1v;
                // Colour is decided from the map as it stood before this edge's write.
                x = int'(ADDRESS[9:0]);
                y = int'(ADDRESS[18:10]);
                if (x >= 640 || y >= 480) begin
                    p1  = 12'h000;
                    p1v = 1'b1;
                end else begin
                    p1  = pal(mmap[x / 4][y / 4]);
                    p1v = known[x / 4][y / 4];
                end
                if (!m_busy) begin
                    tx = int'(WR_ADDR[14:7]);
                    ty = int'(WR_ADDR[6:0]);
                    if (WR_VALID && tx < 160 && ty < 120) begin
                        mmap[tx][ty]  = WR_CLASS;
                        known[tx][ty] = 1'b1;
                    end
                    if (CLR_REQ) begin
                        m_busy = 1'b1;
                        m_left = TILE_N;
                    end
                end else begin
                    n = TILE_N - m_left;
                    mmap[n % 160][n / 160]  = 2'd0;
                    known[n % 160][n / 160] = 1'b1;
                    m_left--;
                    if (m_left == 0) m_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1) begin
                chk("busy_model", {31'd0, CLR_BUSY}, {31'd0, m_busy});
                chk("ready_model", {31'd0, WR_READY}, {31'd0, !m_busy});
                if (p2v) chk("colour_model", {20'd0, COLOUR}, {20'd0, p2});
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic set_pix(input int x, input int y);
        ADDRESS = {9'(y), 10'(x)};
    endtask

    task automatic pix_check(input string name, input int x, input int y, input logic [11:0] exp);
        set_pix(x, y);
        @(negedge CLK);
        @(negedge CLK);
        chk(name, {20'd0, COLOUR}, {20'd0, exp});
    endtask

    task automatic do_write(input int tx, input int ty, input logic [1:0] cls);
        int n = 0;
        WR_ADDR  = {8'(tx), 7'(ty)};
        WR_CLASS = cls;
        WR_VALID = 1'b1;
        while (WR_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("wr_handshake", {31'd0, WR_READY}, 32'd1);
        @(negedge CLK);
        WR_VALID = 1'b0;
    endtask

    // Counts negedge samples with CLR_BUSY high, starting from the sample in hand.
    task automatic count_busy(input string name, input int start, input int pulse_at);
        int n = start;
        while (CLR_BUSY === 1'b1 && n < 20000) begin
            n++;
            CLR_REQ = (n == pulse_at);
            @(negedge CLK);
        end
        CLR_REQ = 1'b0;
        chk(name, n, TILE_N);
        chk({name, "_ready"}, {31'd0, WR_READY}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_colour", {20'd0, COLOUR}, 32'h0);
        chk("reset_ready", {31'd0, WR_READY}, 32'd0);
        chk("reset_busy", {31'd0, CLR_BUSY}, 32'd1);
        RESET = 1'b1;
        count_busy("init_clear_len", 0, 0);

        // Cleared map: every visible pixel is background.
        for (int y = 0; y < 480; y += 37) begin
            for (int x = 0; x < 640; x += 53) begin
                set_pix(x, y);
                @(negedge CLK);
            end
        end
        pix_check("cleared_origin", 0, 0, 12'h000);
        pix_check("cleared_corner", 639, 479, 12'h000);

        // Single tile write and exact latency.
        do_write(10, 5, 2'd1);
        set_pix(0, 0);
        repeat (2) @(negedge CLK);
        set_pix(42, 21);
        @(negedge CLK);
        chk("snake_lat1", {20'd0, COLOUR}, 32'h000);
        @(negedge CLK);
        chk("snake_lat2", {20'd0, COLOUR}, 32'hFF0);
        pix_check("snake_neighbour", 44, 21, 12'h000);

        // Out-of-range pixels stay black even with a wall at the last tile.
        do_write(159, 119, 2'd3);
        pix_check("oor_x", 700, 100, 12'h000);
        pix_check("oor_y", 100, 500, 12'h000);
        pix_check("wall_corner", 639, 479, 12'hF00);

        // Tile X=160 is accepted and dropped.
        do_write(160, 1, 2'd2);
        pix_check("bad_wr_tile01", 0, 4, 12'h000);
        pix_check("bad_wr_tile02", 0, 8, 12'h000);

        // Write and clear in the same cycle; re-pulse mid-clear.
        WR_ADDR  = {8'd20, 7'd20};
        WR_CLASS = 2'd2;
        WR_VALID = 1'b1;
        CLR_REQ  = 1'b1;
        chk("wr_clr_ready", {31'd0, WR_READY}, 32'd1);
        @(negedge CLK);
        WR_VALID = 1'b0;
        CLR_REQ  = 1'b0;
        chk("clr_ready_low", {31'd0, WR_READY}, 32'd0);
        chk("clr_busy_high", {31'd0, CLR_BUSY}, 32'd1);
        set_pix(80, 80);
        @(negedge CLK);
        @(negedge CLK);
        chk("wr_before_sweep", {20'd0, COLOUR}, 32'h00F);
        count_busy("clr_len", 2, 100);
        pix_check("wr_cleared", 80, 80, 12'h000);
        pix_check("corner_cleared", 639, 479, 12'h000);

        // Reset partway through a clear.
        do_write(159, 119, 2'd3);
        pix_check("wall_again", 639, 479, 12'hF00);
        CLR_REQ = 1'b1;
        @(negedge CLK);
        CLR_REQ = 1'b0;
        for (int i = 1; i < 5000; i++) @(negedge CLK);
        chk("pre_reset_colour", {20'd0, COLOUR}, 32'hF00);
        #2 RESET = 1'b0;
        #1;
        chk("async_colour", {20'd0, COLOUR}, 32'h000);
        chk("async_busy", {31'd0, CLR_BUSY}, 32'd1);
        chk("async_ready", {31'd0, WR_READY}, 32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        count_busy("restart_clear_len", 0, 0);
        pix_check("final_corner", 639, 479, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #1000000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
